// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder step per cycle, LSB first; SERIAL_ADDER_SUB_EN adds sub_in (a-b).
// Latency: WIDTH cycles from accept to res_valid.
// Backpressure: result held in DONE until res_ready; start_ready high only in IDLE.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [WIDTH-1:0] b_load;
  logic             carry, carry_load;
  logic             step_sum, step_carry;
  logic             accept, last_step;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);

  assign accept     = start_valid & start_ready;
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));
  assign step_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign step_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  // Sum bits enter at the MSB, so after WIDTH steps bit 0 holds the LSB.
  assign res_nxt    = WIDTH'({step_sum, res_sh} >> 1);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; the final carry then reads as "no borrow".
  assign b_load     = sub_in ? ~b_in : b_in;
  assign carry_load = sub_in | cin;
`else
  assign b_load     = b_in;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= step_carry;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            sum_out   <= res_nxt;
            carry_out <= step_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, scoreboard queue, reset and backpressure corners.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub_in;
`endif
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  vec_t       vecs[$];
  logic [W:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin        (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in     (sub_in),
`endif
    .sum_out    (sum_out),
    .carry_out  (carry_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                              input logic s, input logic [W-1:0] es, input logic ec);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.s = s; v.es = es; v.ec = ec;
    return v;
  endfunction

  function automatic vec_t mk_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return mk(a, b, c, 1'b0, t[W-1:0], t[W]);
  endfunction

  function automatic vec_t mk_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return mk(a, b, 1'b0, 1'b1, d, a >= b);
  endfunction

  // One full transaction; hold>0 keeps res_ready low in DONE, pulse fires a stray start there.
  task automatic run_op(input vec_t v, input bit early_rdy, input int hold, input bit pulse);
    logic [W:0] exp;
    int lat;
    int busy_cnt;
    exp = '0;
    chk("start_ready_idle", 64'(start_ready), 64'(1));
    a_in = v.a; b_in = v.b; cin = v.c;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = v.s;
`endif
    start_valid = 1'b1;
    exp_q.push_back({v.ec, v.es});
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = ~v.a; b_in = W'($urandom); cin = ~v.c;
    res_ready = early_rdy;
    chk("start_ready_run", 64'(start_ready), 64'(0));
    lat = 0;
    busy_cnt = 0;
    while (!res_valid && lat < W + 4) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(W));
    chk("busy_run_cycles", 64'(busy_cnt), 64'(W));
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'(1), 64'(0));
      end else begin
        exp = exp_q.pop_front();
        chk("sum", 64'(sum_out), 64'(exp[W-1:0]));
        chk("carry", 64'(carry_out), 64'(exp[W]));
        chk("busy_done", 64'(busy), 64'(1));
      end
    end else begin
      exp_q.delete();
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        start_valid = 1'b1; a_in = 8'h33; b_in = 8'h44;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_sum", 64'(sum_out), 64'(exp[W-1:0]));
      chk("hold_carry", 64'(carry_out), 64'(exp[W]));
      chk("hold_start_ready", 64'(start_ready), 64'(0));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("exit_valid", 64'(res_valid), 64'(0));
    chk("exit_start_ready", 64'(start_ready), 64'(1));
    chk("exit_busy", 64'(busy), 64'(0));
    if (pulse) begin
      @(posedge clk); #1;
      chk("stray_start_ignored", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    vecs.push_back(mk(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0));
    vecs.push_back(mk(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1));
    vecs.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1));
    for (int c = 0; c < 2; c++) begin
      vecs.push_back(mk_add(8'h00, 8'h00, 1'(c)));
      vecs.push_back(mk_add(8'h80, 8'h80, 1'(c)));
      vecs.push_back(mk_add(8'hAA, 8'h55, 1'(c)));
      vecs.push_back(mk_add(8'h7F, 8'h00, 1'(c)));
    end
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk_add(W'($urandom), W'($urandom), 1'($urandom)));
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back(mk(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0));
    vecs.push_back(mk(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1));
    vecs.push_back(mk(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0));
    vecs.push_back(mk(8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(8'h05, 8'h07, 1'b0, 1'b0, 8'h0C, 1'b0));
    vecs.push_back(mk(8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk_sub(W'($urandom), W'($urandom)));
`endif

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sum", 64'(sum_out), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_start_ready", 64'(start_ready), 64'(1));
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i], i[0], 0, 1'b0);

    // 0x9C + 0x77 + 1 = 0x114, held under backpressure with a stray start in DONE
    run_op(mk(8'h9C, 8'h77, 1'b1, 1'b0, 8'h14, 1'b1), 1'b0, 5, 1'b1);

    // Reset in the middle of RUN abandons the operation
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum", 64'(sum_out), 64'(0));
    chk("midrst_carry", 64'(carry_out), 64'(0));
    chk("midrst_valid", 64'(res_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_start_ready", 64'(start_ready), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'(0));
    run_op(mk(8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0), 1'b0, 0, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
